// File: rtl/aes_pkg.sv
// Shared AES types, round constants and word helpers used by the key
// schedule and the cipher datapath.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_EMIT = 2'd2
  } inv_ks_state_e;

  // Round constants are 1-based; index 0 has no meaning in AES.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational lookup on one byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_inv_key_expand.sv
// AES-128 inverse key schedule: emits round keys 10..0, one per handshake.
// Define AES_INV_KEY_FWD_EN to accept the cipher key and expand forward first.
module aes_inv_key_expand
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         start_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  inv_ks_state_e state, state_next;
  aes_block_t    key_q;
  logic [3:0]    round_q;
  logic          done_q;

  logic          load, step_inv, done_set;
  aes_word_t     w0, w1, w2, w3;
  aes_word_t     sub_in, sub_out, rcon_word;
  logic [3:0]    rcon_idx;
  aes_block_t    inv_next;

  assign {w0, w1, w2, w3} = key_q;

`ifdef AES_INV_KEY_FWD_EN
  logic       step_fwd;
  aes_word_t  f0, f1, f2, f3;

  // Forward and inverse steps share the S-boxes; only their input differs.
  assign sub_in = (state == ST_FWD) ? rot_word(w3) : rot_word(w3 ^ w2);
  assign f0 = w0 ^ sub_out ^ rcon_word;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
`else
  assign sub_in = rot_word(w3 ^ w2);
`endif

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*i +: 8]),
      .y (sub_out[8*i +: 8])
    );
  end

  always_comb begin
    rcon_idx = round_q;
`ifdef AES_INV_KEY_FWD_EN
    if (state == ST_FWD) rcon_idx = round_q + 4'd1;
`endif
    rcon_word = '0;
    if (rcon_idx != 4'd0 && rcon_idx <= 4'd10) rcon_word = {RCON[rcon_idx], 24'h0};
  end

  assign inv_next = {w0 ^ sub_out ^ rcon_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    load       = 1'b0;
    step_inv   = 1'b0;
    done_set   = 1'b0;
`ifdef AES_INV_KEY_FWD_EN
    step_fwd   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
`ifdef AES_INV_KEY_FWD_EN
          state_next = ST_FWD;
`else
          state_next = ST_EMIT;
`endif
        end
      end
`ifdef AES_INV_KEY_FWD_EN
      ST_FWD: begin
        step_fwd = 1'b1;
        if (round_q == LAST_ROUND - 4'd1) state_next = ST_EMIT;
      end
`endif
      ST_EMIT: begin
        if (rk_ready) begin
          if (round_q != 4'd0) begin
            step_inv = 1'b1;
          end else begin
            state_next = ST_IDLE;
            done_set   = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_set;
    end
  end

  // NOTE: the key register is reset so no stale key is ever visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      round_q <= 4'd0;
    end else if (load) begin
      key_q <= key_in;
`ifdef AES_INV_KEY_FWD_EN
      round_q <= 4'd0;
`else
      round_q <= LAST_ROUND;
`endif
`ifdef AES_INV_KEY_FWD_EN
    end else if (step_fwd) begin
      key_q   <= {f0, f1, f2, f3};
      round_q <= round_q + 4'd1;
`endif
    end else if (step_inv) begin
      key_q   <= inv_next;
      round_q <= round_q - 4'd1;
    end
  end

  assign start_ready = (state == ST_IDLE);
  assign rk_valid    = (state == ST_EMIT);
  assign busy        = (state != ST_IDLE);
  assign done        = done_q;
  assign round       = round_q;
  assign round_key   = key_q;

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Randomized bench for aes_inv_key_expand against a forward key-expansion
// model built from GF(2^8) arithmetic.
module tb_aes_inv_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start_ready;
  logic [127:0] key_in = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         busy;
  logic         done;

  aes_inv_key_expand #(.NR(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_ready (start_ready),
    .key_in      (key_in),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .round       (round),
    .round_key   (round_key),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [1:10];
  logic [127:0] sched  [0:10];
  logic [127:0] obs    [0:10];

  localparam logic [127:0] CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

`ifdef AES_INV_KEY_FWD_EN
  localparam int FWD_CYCLES = 10;
`else
  localparam int FWD_CYCLES = 0;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, rc;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      rcon_m[i] = rc;
      rc = xtime(rc);
    end
  endtask

  // Standard forward expansion into w[0..43], grouped into 11 round keys.
  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t ^= {rcon_m[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: rk_ready held high; 1: random stalls; 2: high, plus start poked during EMIT.
  task automatic run_job(input logic [127:0] ck, input int mode);
    int r, k, hs;
    expand(ck);
    start  = 1'b1;
`ifdef AES_INV_KEY_FWD_EN
    key_in = ck;
`else
    key_in = sched[10];
`endif
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    for (int i = 0; i < FWD_CYCLES; i++) begin
      check("fwd_valid_low", rk_valid, 1'b0);
      check("fwd_busy", busy, 1'b1);
      step();
      k++;
    end
    r  = 10;
    hs = 0;
    while (r >= 0 && k < 400) begin
      check("valid", rk_valid, 1'b1);
      check("round", round, 128'(r));
      check("key", round_key, sched[r]);
      obs[r] = round_key;
      if (mode == 2) begin
        start  = 1'b1;
        key_in = ~key_in;
        check("start_ready_emit", start_ready, 1'b0);
      end
      if (mode == 1) rk_ready = ($urandom_range(0, 2) != 0);
      if (rk_ready) begin
        hs++;
        r--;
      end
      step();
      k++;
    end
    start = 1'b0;
    check("job_finished", 128'(r < 0), 128'd1);
    check("handshakes", 128'(hs), 128'd11);
    check("done_pulse", done, 1'b1);
    check("done_start_ready", start_ready, 1'b1);
    check("done_valid_low", rk_valid, 1'b0);
    check("done_busy_low", busy, 1'b0);
    if (mode != 1) check("done_cycle", 128'(k), 128'(12 + FWD_CYCLES));
  endtask

  initial begin
    int n;
    build_tables();

    #2;
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_valid", rk_valid, 1'b0);
    check("rst_round", round, 4'd0);
    check("rst_key", round_key, 128'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    #10 rst_n = 1'b1;
    step();

    run_job(CIPHER_KEY, 0);
    check("vec_r10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("vec_r9",  obs[9],  128'hac7766f319fadc2128d12941575c006e);
    check("vec_r1",  obs[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("vec_r0",  obs[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Each run_job starts in the previous job's done cycle: back-to-back.
    run_job(rand_key(), 0);
    run_job(CIPHER_KEY, 1);
    run_job(rand_key(), 2);
    for (int j = 0; j < 4; j++) run_job(rand_key(), 1);
    step();
    check("done_falls", done, 1'b0);

    // Reset in the middle of a job.
    expand(rand_key());
    start  = 1'b1;
`ifdef AES_INV_KEY_FWD_EN
    key_in = sched[0];
`else
    key_in = sched[10];
`endif
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(rk_valid && round == 4'd5) && n < 50) begin
      step();
      n++;
    end
    check("reach_round5", 128'(n < 50), 128'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rk_valid, 1'b0);
    check("mid_rst_round", round, 4'd0);
    check("mid_rst_key", round_key, 128'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_start_ready", start_ready, 1'b1);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_start_ready", start_ready, 1'b1);
    check("post_rst_valid", rk_valid, 1'b0);
    run_job(rand_key(), 1);
    run_job(CIPHER_KEY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
